// File: rtl/mgnt_pkg.sv
// Shared definitions for the management-bus arbiter.
//   TGT_W / ADDR_W / DATA_W : system management bus field widths
//   state_e                 : arbiter FSM encoding
//   tgt_ok()                : target select is a legal one-hot value
package mgnt_pkg;

    localparam int TGT_W  = 6;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    function automatic logic tgt_ok(input logic [TGT_W-1:0] t);
        return (t != '0) && ((t & (t - TGT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/mgnt_rr_arb.sv
// Round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : NREQ request bits
//   en_i         : take the grant this cycle (advances the pointer)
//   gnt_o        : one-hot grant, combinational from req_i and the pointer
module mgnt_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q, ptr_d, win;
    logic [PW:0]       sum;
    logic [2*NREQ-1:0] dbl;
    logic              found;

    // Rotate the request vector so bit 0 is the highest-priority index, take
    // the first set bit, then map the offset back to an absolute index.
    always_comb begin
        dbl   = {req_i, req_i} >> ptr_q;
        found = 1'b0;
        sum   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && dbl[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (PW+1)'(j);
            end
        end
        if (sum >= (PW+1)'(NREQ))
            sum = sum - (PW+1)'(NREQ);
        win = sum[PW-1:0];
        for (int i = 0; i < NREQ; i++)
            gnt_o[i] = found && (win == PW'(i));
        ptr_d = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            ptr_q <= '0;
        else if (en_i && found)
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mgnt_arbiter.sv
// Management-bus arbiter: serialises register accesses from NREQ requesters
// onto one system management bus, one transaction outstanding at a time.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : per-requester request (valid held until req_ready)
//   req_ready       : one-cycle accept pulse to the granted requester
//   resp_valid/data : read beats forwarded combinationally from the bus
//   resp_last       : final beat of a read
//   resp_err        : bad target or response timeout
//   sys_req_*       : one-cycle request strobe to the system bus
//   sys_resp_*      : read-data beats from the system bus, MSB first
module mgnt_arbiter
    import mgnt_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int MGNT_REG_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_wr,
    input  logic [NREQ-1:0][TGT_W-1:0]  req_tgt,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        resp_last,
    output logic [NREQ-1:0]             resp_err,
    output logic [TGT_W-1:0]            sys_req_valid,
    output logic                        sys_req_wr,
    output logic [ADDR_W-1:0]           sys_req_addr,
    input  logic                        sys_resp_valid,
    input  logic [DATA_W-1:0]           sys_resp_data
);

    localparam int BEATS = MGNT_REG_WIDTH / 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d, gnt;
    logic                wr_q, wr_d;
    logic [TGT_W-1:0]    tgt_q, tgt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [TW-1:0]       tmo_q, tmo_d;

    logic                arb_en;
    logic                sel_wr;
    logic [TGT_W-1:0]    sel_tgt;
    logic [ADDR_W-1:0]   sel_addr;

    assign arb_en = !rst && (state_q == ST_IDLE) && (|req_valid);

    mgnt_rr_arb #(.NREQ(NREQ)) u_rr (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req_valid),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    // One-hot mux of the winner's request fields.
    always_comb begin
        sel_wr   = 1'b0;
        sel_tgt  = '0;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_wr   = sel_wr   | req_wr[i];
                sel_tgt  = sel_tgt  | req_tgt[i];
                sel_addr = sel_addr | req_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            tgt_q   <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs are all gated by rst so a reset landing on a beat or on the
    // timeout cycle aborts silently.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        wr_d          = wr_q;
        tgt_d         = tgt_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        req_ready     = '0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_last     = 1'b0;
        resp_err      = '0;
        sys_req_valid = '0;
        sys_req_wr    = 1'b0;
        sys_req_addr  = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_en) begin
                        gnt_d   = gnt;
                        wr_d    = sel_wr;
                        tgt_d   = sel_tgt;
                        addr_d  = sel_addr;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    req_ready = gnt_q;
                    beat_d    = '0;
                    tmo_d     = '0;
                    if (!tgt_ok(tgt_q)) begin
                        resp_err = gnt_q;
                        state_d  = ST_IDLE;
                    end else begin
                        sys_req_valid = tgt_q;
                        sys_req_wr    = wr_q;
                        sys_req_addr  = addr_q;
                        state_d       = wr_q ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sys_resp_valid) begin
                        resp_valid = gnt_q;
                        resp_data  = sys_resp_data;
                        beat_d     = beat_q + BW'(1);
                        tmo_d      = '0;
                        if (beat_q == BW'(BEATS-1)) begin
                            resp_last = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else if (tmo_q == TW'(TIMEOUT-1)) begin
                        // This idle cycle is the TIMEOUT-th since the last beat
                        // (or since issue); the partial read is dropped.
                        resp_err = gnt_q;
                        state_d  = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mgnt_arbiter.sv
module tb_mgnt_arbiter;

    localparam int NREQ    = 4;
    localparam int REGW    = 32;
    localparam int TIMEOUT = 16;
    localparam int BEATS   = REGW / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_wr;
    logic [NREQ-1:0][5:0]  req_tgt;
    logic [NREQ-1:0][7:0]  req_addr;
    logic [NREQ-1:0]       req_ready, resp_valid, resp_err;
    logic [7:0]            resp_data;
    logic                  resp_last;
    logic [5:0]            sys_req_valid;
    logic                  sys_req_wr;
    logic [7:0]            sys_req_addr;
    logic                  sys_resp_valid;
    logic [7:0]            sys_resp_data;

    always #5 clk = ~clk;

    mgnt_arbiter #(.NREQ(NREQ), .MGNT_REG_WIDTH(REGW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_tgt        (req_tgt),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_last      (resp_last),
        .resp_err       (resp_err),
        .sys_req_valid  (sys_req_valid),
        .sys_req_wr     (sys_req_wr),
        .sys_req_addr   (sys_req_addr),
        .sys_resp_valid (sys_resp_valid),
        .sys_resp_data  (sys_resp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending requests and next-priority index.
    logic [NREQ-1:0] pend;
    bit              p_wr   [NREQ];
    logic [5:0]      p_tgt  [NREQ];
    logic [7:0]      p_addr [NREQ];
    int              rr_ptr;
    logic [7:0]      dird [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        for (int k = 0; k < NREQ; k++)
            if (pend[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [5:0] rand_tgt();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return 6'(1) << $urandom_range(0, 5);
        if (r == 7) return 6'h00;
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_wr[i]   = p_wr[i];
            req_tgt[i]  = p_tgt[i];
            req_addr[i] = p_addr[i];
        end
    endtask

    task automatic refill();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
                pend[i]   = 1'b1;
                p_wr[i]   = 1'($urandom_range(0, 1));
                p_tgt[i]  = rand_tgt();
                p_addr[i] = 8'($urandom);
            end
        end
        if (pend == '0) begin
            pend[0] = 1'b1; p_wr[0] = 1'b0; p_tgt[0] = 6'h01; p_addr[0] = 8'h5C;
        end
    endtask

    // One arbitration round starting with the FSM idle. tmo_after >= 0 means
    // a read gets only that many beats and must then time out.
    task automatic run_round(input int tmo_after, input bit dir, output logic [NREQ-1:0] got_rdy);
        int g, nb, gap;
        logic [5:0] t;
        bit w, good;
        logic [7:0] a, d;
        @(negedge clk);
        drive_reqs();
        sys_resp_valid = 1'($urandom_range(0, 1));
        sys_resp_data  = 8'($urandom);
        #1;
        chk("idle_rvalid", resp_valid, 0);
        chk("idle_ready", req_ready, 0);
        chk("idle_sysvld", sys_req_valid, 0);
        g = pick();
        rr_ptr = (g + 1) % NREQ;
        t = p_tgt[g]; w = p_wr[g]; a = p_addr[g];
        good = ($countones(t) == 1);
        // ISSUE cycle: requester drops valid and scribbles its fields.
        @(negedge clk);
        pend[g] = 1'b0;
        p_tgt[g] = 6'($urandom); p_addr[g] = 8'($urandom); p_wr[g] = 1'($urandom);
        drive_reqs();
        sys_resp_valid = 1'($urandom_range(0, 1));
        #1;
        got_rdy = req_ready;
        chk("ready", req_ready, oh(g));
        chk("issue_err", resp_err, good ? '0 : oh(g));
        chk("sys_valid", sys_req_valid, good ? t : 6'h00);
        chk("issue_rvalid", resp_valid, 0);
        if (good) begin
            chk("sys_wr", sys_req_wr, w);
            chk("sys_addr", sys_req_addr, a);
        end
        if (!good || w) return;
        nb = (tmo_after >= 0) ? tmo_after : BEATS;
        for (int b = 0; b < nb; b++) begin
            gap = dir ? 0 : $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                sys_resp_valid = 1'b0;
                #1;
                chk("gap_quiet", {resp_valid, resp_err}, 0);
            end
            @(negedge clk);
            d = dir ? dird[b % 4] : 8'($urandom);
            sys_resp_valid = 1'b1;
            sys_resp_data  = d;
            #1;
            chk("beat_vld", resp_valid, oh(g));
            chk("beat_data", resp_data, d);
            chk("beat_last", resp_last, (b == BEATS - 1));
        end
        if (tmo_after >= 0) begin
            for (int c = 1; c <= TIMEOUT; c++) begin
                @(negedge clk);
                sys_resp_valid = 1'b0;
                #1;
                chk("tmo_err", resp_err, (c == TIMEOUT) ? oh(g) : '0);
            end
        end
    endtask

    task automatic reset_mid_read();
        logic [NREQ-1:0] r;
        int g;
        pend = '0;
        pend[2] = 1'b1; p_wr[2] = 1'b0; p_tgt[2] = 6'h04; p_addr[2] = 8'h33;
        @(negedge clk);
        drive_reqs();
        sys_resp_valid = 1'b0;
        g = pick();
        rr_ptr = (g + 1) % NREQ;
        @(negedge clk);
        pend[g] = 1'b0;
        drive_reqs();
        #1;
        r = req_ready;
        chk("rst_ready", r, oh(g));
        @(negedge clk);
        sys_resp_valid = 1'b1;
        sys_resp_data  = 8'h5A;
        #1;
        chk("rst_beat1", resp_valid, oh(g));
        @(negedge clk);
        sys_resp_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_cycle_out", {resp_valid, resp_err, resp_last}, 0);
        @(negedge clk);
        #1;
        chk("rst_outs", {req_ready, resp_valid, resp_last, resp_err, sys_req_valid, sys_req_wr, sys_req_addr}, 0);
        rst = 1'b0;
        rr_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sys_resp_valid = 1'b1;
            sys_resp_data  = 8'($urandom);
            #1;
            chk("post_rst_rvalid", {resp_valid, resp_last, resp_err}, 0);
        end
        sys_resp_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rdy;
        int order [5] = '{0, 1, 2, 3, 0};
        int tmo;
        rst = 1'b1;
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_wr[i] = 1'b0; p_tgt[i] = '0; p_addr[i] = '0;
        end
        drive_reqs();
        sys_resp_valid = 1'b0;
        sys_resp_data  = '0;
        rr_ptr = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {req_ready, resp_valid, resp_last, resp_err, sys_req_valid, sys_req_wr, sys_req_addr}, 0);
        rst = 1'b0;

        // All four writing continuously: grants rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!pend[j] || n == 0) begin
                    pend[j] = 1'b1; p_wr[j] = 1'b1;
                    p_tgt[j] = 6'(1) << $urandom_range(0, 5);
                    p_addr[j] = 8'($urandom);
                end
            end
            run_round(-1, 1'b0, rdy);
            chk("rr_order", rdy, oh(order[n]));
        end

        // Directed read on requester 1, bytes DE AD BE EF.
        pend = '0;
        pend[1] = 1'b1; p_wr[1] = 1'b0; p_tgt[1] = 6'h02; p_addr[1] = 8'h10;
        run_round(-1, 1'b1, rdy);

        // Illegal target 0x03.
        pend = '0;
        pend[3] = 1'b1; p_wr[3] = 1'b0; p_tgt[3] = 6'h03; p_addr[3] = 8'h44;
        run_round(-1, 1'b0, rdy);

        // Two beats then silence.
        pend = '0;
        pend[0] = 1'b1; p_wr[0] = 1'b0; p_tgt[0] = 6'h08; p_addr[0] = 8'h21;
        run_round(2, 1'b0, rdy);

        reset_mid_read();

        for (int n = 0; n < 60; n++) begin
            refill();
            tmo = ($urandom_range(0, 7) == 0) ? $urandom_range(0, BEATS - 1) : -1;
            run_round(tmo, 1'b0, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mgnt_arbiter.md
MGNT_ARBITER -- requirements
Module: mgnt_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of management requesters (SPI register controller, stat poller, ...).
REQ-002 SHALL have parameter MGNT_REG_WIDTH, default 32, register width in bits; BEATS = MGNT_REG_WIDTH/8 response bytes per read.
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles allowed between read response beats.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester request, held until req_ready.
REQ-007 req_wr  input  NREQ  per-requester 1=write, 0=read.
REQ-008 req_tgt  input  6*NREQ  per-requester one-hot target port select.
REQ-009 req_addr  input  8*NREQ  per-requester register address.
REQ-010 req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
REQ-011 resp_valid  output  NREQ  per-requester read-data beat strobe.
REQ-012 resp_data  output  8  shared read-data byte, valid with any resp_valid bit.
REQ-013 resp_last  output  1  marks final beat of a read.
REQ-014 resp_err  output  NREQ  one-cycle error pulse (bad target or timeout).
REQ-015 sys_req_valid  output  6  one-hot target strobe to the system management bus.
REQ-016 sys_req_wr  output  1  write qualifier, valid with sys_req_valid.
REQ-017 sys_req_addr  output  8  register address, valid with sys_req_valid.
REQ-018 sys_resp_valid  input  1  read-data beat from the system management bus.
REQ-019 sys_resp_data  input  8  read-data byte, MSB-first across beats.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding at any time.
REQ-021 IDLE: if any req_valid, SHALL select grant g round-robin starting from the index after the last grant, latch req_wr/req_tgt/req_addr of g, go to ISSUE.
REQ-022 ISSUE (exactly one cycle): SHALL drive req_ready[g]=1, sys_req_valid=latched tgt, sys_req_wr, sys_req_addr; request seen in cycle N yields sys_req_valid in cycle N+1.
REQ-023 After ISSUE, write SHALL return to IDLE (no response expected); read SHALL go to WAIT with beat counter=0, timeout counter=0.
REQ-024 WAIT: each sys_resp_valid SHALL be forwarded same cycle (combinational) as resp_valid[g]=1, resp_data=sys_resp_data, beat counter +1.
REQ-025 On beat BEATS-1 SHALL assert resp_last with that beat and return to IDLE next cycle.
REQ-026 Timeout counter SHALL clear on each beat and increment otherwise; on reaching TIMEOUT SHALL pulse resp_err[g], return to IDLE, discard the partial read.
REQ-027 Latched tgt zero or not one-hot: SHALL skip bus issue, pulse req_ready[g] and resp_err[g] together in the ISSUE cycle, return to IDLE.
REQ-028 sys_resp_valid outside WAIT SHALL be ignored; no resp_valid produced.
REQ-029 Round-robin pointer SHALL update only on grant; with all requesters continuously valid grants SHALL rotate 0,1,...,NREQ-1,0.
REQ-030 Changes to req_* of the granted requester after IDLE SHALL not affect the transaction in flight.

Reset
REQ-031 On rst SHALL enter IDLE, rr pointer=0 (requester 0 has first priority), counters=0; req_ready, resp_valid, resp_last, resp_err, sys_req_valid, sys_req_wr = 0; sys_req_addr = 0.
REQ-032 Reset mid-transaction SHALL abort it without any resp_err or resp_last pulse; subsequent beats ignored.

Structure
REQ-033 Package mgnt_pkg SHALL hold FSM state encoding, target width 6, address/data width 8.
REQ-034 Round-robin selection SHALL be sub-module mgnt_rr_arb (NREQ-bit request in, one-hot grant out, pointer update on enable).

Verification
REQ-035 Req 1 read tgt=0x02 addr=0x10; 4 beats 0xDE,0xAD,0xBE,0xEF -> sys_req_valid=0x02 one cycle, resp_valid[1] x4, resp_last on 0xEF.
REQ-036 All 4 requesters writing continuously -> grant order 0,1,2,3,0; one sys_req_valid pulse per grant, sys_req_wr=1.
REQ-037 Read, 2 beats then silence -> resp_err[g] pulse exactly TIMEOUT cycles after beat 2; FSM in IDLE.
REQ-038 req_tgt=0x03 -> req_ready and resp_err same cycle, sys_req_valid stays 0.
REQ-039 rst asserted after beat 1 of a read -> all outputs 0 next cycle, later beats produce no resp_valid.
REQ-040 sys_resp_valid pulsed while IDLE -> no resp_valid on any requester.
